// File: rtl/teclado_4x4.sv
`default_nettype none
// ============================================================================
// teclado_4x4 : 4x4 active-low keypad scanner, debouncer and key encoder
// Rev 1.0
// ============================================================================
module teclado_4x4 #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] tecla,
    output logic       numero_en,
    output logic       operando_en,
    output logic       igual_en,
    output logic       borrar_en,
    output logic       tecla_activa
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync_q, sync_d;
    logic [3:0]       f_s_q, f_s_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       tecla_q, tecla_d;
    logic             accept_q, accept_d;
    logic             activa_q, activa_d;
    logic [3:0]       stb_q, stb_d;     // {borrar, igual, operando, numero}
    logic [1:0]       low_row;
    logic [3:0]       code;

    always_comb begin
        low_row = 2'd3;
        if (!f_s_q[2]) low_row = 2'd2;
        if (!f_s_q[1]) low_row = 2'd1;
        if (!f_s_q[0]) low_row = 2'd0;
    end

    always_comb begin
        case ({row_q, col_q})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
    end

    always_comb begin
        sync_d   = filas;
        f_s_d    = sync_q;
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        div_d    = div_q;
        deb_d    = deb_q;
        pat_d    = pat_q;
        tecla_d  = tecla_q;
        accept_d = 1'b0;
        activa_d = activa_q;
        stb_d    = 4'b0000;

        // Code and strobe land together one cycle after acceptance.
        if (accept_q) begin
            tecla_d = code;
            if (code <= 4'h9)      stb_d[0] = 1'b1;
            else if (code == 4'hE) stb_d[3] = 1'b1;
            else if (code == 4'hF) stb_d[2] = 1'b1;
            else                   stb_d[1] = 1'b1;
        end

        case (state_q)
            SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (f_s_q != 4'hF) begin
                        pat_d   = f_s_q;
                        row_d   = low_row;
                        deb_d   = '0;
                        state_d = DEB_PRESS;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DEB_PRESS: begin
                if (f_s_q != pat_q) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    div_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    accept_d = 1'b1;
                    activa_d = 1'b1;
                    deb_d    = '0;
                    state_d  = HELD;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            HELD: begin
                if (f_s_q != 4'hF) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    activa_d = 1'b0;
                    deb_d    = '0;
                    div_d    = '0;
                    state_d  = SCAN;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SCAN;
            sync_q   <= 4'hF;
            f_s_q    <= 4'hF;
            col_q    <= 2'd0;
            row_q    <= 2'd0;
            div_q    <= '0;
            deb_q    <= '0;
            pat_q    <= 4'hF;
            tecla_q  <= 4'h0;
            accept_q <= 1'b0;
            activa_q <= 1'b0;
            stb_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            f_s_q    <= f_s_d;
            col_q    <= col_d;
            row_q    <= row_d;
            div_q    <= div_d;
            deb_q    <= deb_d;
            pat_q    <= pat_d;
            tecla_q  <= tecla_d;
            accept_q <= accept_d;
            activa_q <= activa_d;
            stb_q    <= stb_d;
        end
    end

    assign columnas     = ~(4'b0001 << col_q);
    assign tecla        = tecla_q;
    assign numero_en    = stb_q[0];
    assign operando_en  = stb_q[1];
    assign igual_en     = stb_q[2];
    assign borrar_en    = stb_q[3];
    assign tecla_activa = activa_q;

endmodule
`default_nettype wire

// File: tb/tb_teclado_4x4.sv
`default_nettype none
// ============================================================================
// tb_teclado_4x4 : randomized keypad stimulus against a timestamp-based model
// Rev 1.0
// ============================================================================
module tb_teclado_4x4;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;
    // Indexed row*4 + col.
    localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                           4'h4, 4'h5, 4'h6, 4'hB,
                                           4'h7, 4'h8, 4'h9, 4'hC,
                                           4'hE, 4'h0, 4'hF, 4'hD};

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [3:0] tecla;
    logic       numero_en, operando_en, igual_en, borrar_en, tecla_activa;
    logic [15:0] press_m;

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0] obs [$];   // {class, tecla}; class 0 num, 1 op, 2 igual, 3 borrar

    always #5 clk = ~clk;

    teclado_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEBOUNCE_CYC)) dut (
        .clk(clk), .reset(reset), .filas(filas), .columnas(columnas),
        .tecla(tecla), .numero_en(numero_en), .operando_en(operando_en),
        .igual_en(igual_en), .borrar_en(borrar_en), .tecla_activa(tecla_activa)
    );

    // Keypad: a closed switch pulls its row to whichever column is driven low.
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (press_m[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int cls_of(input logic [3:0] k);
        if (k <= 4'h9) return 0;
        if (k == 4'hE) return 3;
        if (k == 4'hF) return 2;
        return 1;
    endfunction

    // Reference model: scan slots, debounce and release expressed as time stamps.
    int         m_cyc, m_origin, m_cap, m_last_low, m_mode, m_col, m_row;
    logic [3:0] m_s1, m_fs, m_pat, m_tecla, m_stb, m_seen;
    logic       m_act, m_emit;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cyc = 0; m_origin = 1; m_cap = 0; m_last_low = 0;
            m_mode = 0; m_col = 0; m_row = 0;
            m_s1 = 4'hF; m_fs = 4'hF; m_pat = 4'hF; m_tecla = 4'h0;
            m_stb = 4'h0; m_act = 1'b0; m_emit = 1'b0;
        end else begin
            m_cyc++;
            m_seen = 4'hF;
            for (int r = 0; r < 4; r++) if (press_m[r*4+m_col]) m_seen[r] = 1'b0;
            m_stb = 4'h0;
            if (m_emit) begin
                m_tecla = KEYMAP[m_row*4+m_col];
                m_stb   = 4'(4'b0001 << cls_of(m_tecla));
            end
            m_emit = 1'b0;
            if (m_mode == 0) begin
                if ((m_cyc - m_origin) % SCAN_DIV == SCAN_DIV - 1) begin
                    if (m_fs != 4'hF) begin
                        m_mode = 1; m_cap = m_cyc; m_pat = m_fs; m_row = 3;
                        for (int r = 3; r >= 0; r--) if (!m_fs[r]) m_row = r;
                    end else begin
                        m_col = (m_col + 1) % 4;
                    end
                end
            end else if (m_mode == 1) begin
                if (m_fs != m_pat) begin
                    m_mode = 0; m_col = (m_col + 1) % 4; m_origin = m_cyc + 1;
                end else if (m_cyc - m_cap == DEBOUNCE_CYC) begin
                    m_mode = 2; m_emit = 1'b1; m_act = 1'b1; m_last_low = m_cyc;
                end
            end else begin
                if (m_fs != 4'hF) m_last_low = m_cyc;
                else if (m_cyc - m_last_low == DEBOUNCE_CYC) begin
                    m_mode = 0; m_act = 1'b0; m_origin = m_cyc + 1;
                end
            end
            m_fs = m_s1;
            m_s1 = m_seen;
        end
    end

    always @(negedge clk) begin
        chk("outputs {col,tecla,num,op,igual,borrar,activa}",
            32'({columnas, tecla, numero_en, operando_en, igual_en, borrar_en, tecla_activa}),
            32'({~(4'b0001 << m_col[1:0]), m_tecla, m_stb[0], m_stb[1], m_stb[2], m_stb[3], m_act}));
        if (numero_en)   obs.push_back({2'd0, tecla});
        if (operando_en) obs.push_back({2'd1, tecla});
        if (igual_en)    obs.push_back({2'd2, tecla});
        if (borrar_en)   obs.push_back({2'd3, tecla});
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [5:0] obs_at(input int i);
        if (i < obs.size()) return obs[i];
        return 6'h3F;
    endfunction

    task automatic tap(input int k, input int hold, input int gap);
        press_m[k] = 1'b1;
        tick(hold);
        press_m = '0;
        tick(gap);
    endtask

    initial begin
        press_m = '0;
        reset   = 1'b1;
        #1 reset = 1'b0;

        // Reset state and free-running scan
        tick(3);
        chk("reset_columnas", 32'(columnas), 32'h E);
        chk("reset_tecla", 32'(tecla), 32'h0);
        chk("reset_strobes_activa",
            32'({numero_en, operando_en, igual_en, borrar_en, tecla_activa}), 32'h0);
        reset = 1'b1;
        tick(3);  chk("scan_col0", 32'(columnas), 32'hE);
        tick(4);  chk("scan_col1", 32'(columnas), 32'hD);
        tick(4);  chk("scan_col2", 32'(columnas), 32'hB);
        tick(4);  chk("scan_col3", 32'(columnas), 32'h7);
        tick(4);  chk("scan_wrap", 32'(columnas), 32'hE);

        // Clean press of 5, release timing
        obs.delete();
        press_m[5] = 1'b1;
        tick(100);
        chk("key5_count", 32'(obs.size()), 32'd1);
        chk("key5_entry", 32'(obs_at(0)), 32'({2'd0, 4'h5}));
        press_m = '0;
        tick(9);  chk("release_activa_still_high", 32'(tecla_activa), 32'd1);
        tick(1);  chk("release_activa_low", 32'(tecla_activa), 32'd0);
        tick(20);

        // Bouncy press of A
        obs.delete();
        for (int i = 0; i < 7; i++) begin
            press_m[3] = ~press_m[3];
            tick(3);
        end
        press_m[3] = 1'b1;
        chk("bounce_quiet", 32'(obs.size()), 32'd0);
        tick(80);
        chk("keyA_count", 32'(obs.size()), 32'd1);
        chk("keyA_entry", 32'(obs_at(0)), 32'({2'd1, 4'hA}));
        press_m = '0;
        tick(40);

        // Sequence *, #, 0
        obs.delete();
        tap(12, 60, 60);
        tap(14, 60, 60);
        tap(13, 60, 60);
        chk("seq_count", 32'(obs.size()), 32'd3);
        chk("seq_star", 32'(obs_at(0)), 32'({2'd3, 4'hE}));
        chk("seq_hash", 32'(obs_at(1)), 32'({2'd2, 4'hF}));
        chk("seq_zero", 32'(obs_at(2)), 32'({2'd0, 4'h0}));

        // Hold 1, press 9 alongside, release both, then fresh 9
        obs.delete();
        press_m[0] = 1'b1;
        tick(40);
        press_m[10] = 1'b1;
        tick(40);
        press_m = '0;
        tick(40);
        chk("multi_count", 32'(obs.size()), 32'd1);
        chk("multi_entry", 32'(obs_at(0)), 32'({2'd0, 4'h1}));
        tap(10, 60, 40);
        chk("fresh9_count", 32'(obs.size()), 32'd2);
        chk("fresh9_entry", 32'(obs_at(1)), 32'({2'd0, 4'h9}));

        // Reset while 7 is held
        press_m[8] = 1'b1;
        tick(50);
        chk("held7_activa", 32'(tecla_activa), 32'd1);
        reset = 1'b0;
        #1;
        chk("midreset_columnas", 32'(columnas), 32'hE);
        chk("midreset_tecla", 32'(tecla), 32'h0);
        chk("midreset_strobes_activa",
            32'({numero_en, operando_en, igual_en, borrar_en, tecla_activa}), 32'h0);
        obs.delete();
        tick(2);
        reset = 1'b1;
        tick(60);
        chk("redetect7_count", 32'(obs.size()), 32'd1);
        chk("redetect7_entry", 32'(obs_at(0)), 32'({2'd0, 4'h7}));
        press_m = '0;
        tick(40);

        // Randomized presses, bounces, short taps and second keys
        for (int ep = 0; ep < 30; ep++) begin
            int k;
            k = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < int'($urandom_range(2, 10)); b++) begin
                    press_m[k] = ~press_m[k];
                    tick(int'($urandom_range(1, 3)));
                end
            end
            press_m[k] = 1'b1;
            tick(int'($urandom_range(4, 90)));
            if ($urandom_range(0, 2) == 0) begin
                press_m[$urandom_range(0, 15)] = 1'b1;
                tick(int'($urandom_range(5, 30)));
            end
            press_m = '0;
            tick(int'($urandom_range(0, 50)));
        end
        tick(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
